// File: rtl/game_ctrl.sv
// game_ctrl: top-level Space Invaders sequencer.
// Gates the frame tick to the player/enemy/bullet datapaths and walks the
// game through level-start, play, hit-pause, level-clear and game-over.
// Tracks enemies remaining, score (saturating at 9999) and level, and raises
// an extra-life request on every even level.
// Optional: define GAME_CTRL_HISCORE_EN to build the high-score register;
// without it hiscore_o is tied to 0.
module game_ctrl #(
   parameter int enemies_p      = 55,
   parameter int num_levels_p   = 8,
   parameter int delay_frames_p = 60,
   parameter int kill_score_p   = 10
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        frame_i,
   input  logic        start_i,
   input  logic        player_hit_i,
   input  logic [1:0]  lives_i,
   input  logic        enemy_killed_i,
   input  logic        invaded_i,
   output logic        run_o,
   output logic        frame_o,
   output logic        level_reset_o,
   output logic        add_life_o,
   output logic [3:0]  level_o,
   output logic [5:0]  enemies_left_o,
   output logic [13:0] score_o,
   output logic [2:0]  state_o,
   output logic [13:0] hiscore_o
);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      LEVEL_START = 3'd1,
      PLAY        = 3'd2,
      PAUSED      = 3'd3,
      LEVEL_CLEAR = 3'd4,
      GAME_OVER   = 3'd5
   } state_t;

   localparam logic [13:0] SCORE_MAX  = 14'd9999;
   localparam logic [5:0]  ENEMIES    = 6'(enemies_p);
   localparam logic [3:0]  LAST_LVL   = 4'(num_levels_p);
   localparam logic [7:0]  DELAY_LAST = 8'(delay_frames_p - 1);
   localparam logic [14:0] KILL_PTS   = 15'(kill_score_p);

   state_t      state;
   logic        start_q;
   logic [7:0]  frame_cnt;
   logic        start_rise;
   logic        lose;
   logic [14:0] score_sum;
   logic [13:0] score_nxt;
   logic [5:0]  left_nxt;
   logic [3:0]  lvl_nxt;

   // Kill arithmetic and loss detection used while in PLAY
   always_comb begin
      start_rise = start_i & ~start_q;
      lose       = invaded_i | (player_hit_i & (lives_i == 2'd0));
      score_sum  = {1'b0, score_o} + KILL_PTS;
      score_nxt  = score_o;
      left_nxt   = enemies_left_o;
      if (enemy_killed_i) begin
         score_nxt = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[13:0];
         left_nxt  = (enemies_left_o != 6'd0) ? enemies_left_o - 6'd1 : 6'd0;
      end
      lvl_nxt = (level_o == LAST_LVL) ? 4'd1 : level_o + 4'd1;
   end

   assign state_o = state;
   assign frame_o = frame_i & run_o;

   // Game phase sequencer with registered outputs; run_o tracks state == PLAY
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state          <= IDLE;
         run_o          <= 1'b0;
         level_reset_o  <= 1'b0;
         add_life_o     <= 1'b0;
         level_o        <= 4'd1;
         enemies_left_o <= ENEMIES;
         score_o        <= 14'd0;
         frame_cnt      <= 8'd0;
         start_q        <= 1'b1;   // button held through reset must not start a game
      end else begin
         start_q       <= start_i;
         level_reset_o <= 1'b0;
         case (state)
            IDLE, GAME_OVER: begin
               if (start_rise) begin
                  score_o        <= 14'd0;
                  level_o        <= 4'd1;
                  level_reset_o  <= 1'b1;
                  enemies_left_o <= ENEMIES;
                  frame_cnt      <= 8'd0;
                  state          <= LEVEL_START;
               end
            end
            LEVEL_START: begin
               if (frame_i) begin
                  // the player block has sampled add_life on this frame
                  add_life_o <= 1'b0;
                  if (frame_cnt == DELAY_LAST) begin
                     state <= PLAY;
                     run_o <= 1'b1;
                  end else begin
                     frame_cnt <= frame_cnt + 8'd1;
                  end
               end
            end
            PLAY: begin
               score_o        <= score_nxt;
               enemies_left_o <= left_nxt;
               if (lose) begin
                  state <= GAME_OVER;
                  run_o <= 1'b0;
               end else if (player_hit_i) begin
                  state <= PAUSED;
                  run_o <= 1'b0;
               end else if (left_nxt == 6'd0) begin
                  state <= LEVEL_CLEAR;
                  run_o <= 1'b0;
               end
            end
            PAUSED: begin
               if (start_rise) begin
                  if (enemies_left_o == 6'd0) begin
                     state <= LEVEL_CLEAR;
                  end else begin
                     state <= PLAY;
                     run_o <= 1'b1;
                  end
               end
            end
            LEVEL_CLEAR: begin
               level_o        <= lvl_nxt;
               if (!lvl_nxt[0]) add_life_o <= 1'b1;
               level_reset_o  <= 1'b1;
               enemies_left_o <= ENEMIES;
               frame_cnt      <= 8'd0;
               state          <= LEVEL_START;
            end
            default: begin
               state <= IDLE;
               run_o <= 1'b0;
            end
         endcase
      end
   end

`ifdef GAME_CTRL_HISCORE_EN
   logic [13:0] hiscore_q;
   logic        enter_go;

   assign enter_go  = (state == PLAY) & lose;
   assign hiscore_o = hiscore_q;

   // Capture the final score of a game if it beats the best so far
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         hiscore_q <= 14'd0;
      end else if (enter_go && (score_nxt > hiscore_q)) begin
         hiscore_q <= score_nxt;
      end
   end
`else
   assign hiscore_o = 14'd0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed scenarios plus randomized play for game_ctrl,
// checked against a phase-level reference model of the game rules.
module tb_game_ctrl;
   localparam int E = 3, D = 2, L = 8, K = 10;
`ifdef GAME_CTRL_HISCORE_EN
   localparam bit HI = 1'b1;
`else
   localparam bit HI = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        reset_n_i, frame_i, start_i, player_hit_i, enemy_killed_i, invaded_i;
   logic [1:0]  lives_i;
   logic        run_o, frame_o, level_reset_o, add_life_o;
   logic [3:0]  level_o;
   logic [5:0]  enemies_left_o;
   logic [13:0] score_o, hiscore_o;
   logic [2:0]  state_o;

   int n_checks = 0, n_fail = 0;

   // reference model: game phase (numbered as on state_o) and counters
   int m_state, m_level, m_left, m_score, m_hi, m_fcnt;
   bit m_addlife, m_lrst, m_startq;

   always #5 clk_i = ~clk_i;

   game_ctrl #(.enemies_p(E), .num_levels_p(L), .delay_frames_p(D), .kill_score_p(K)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .frame_i(frame_i), .start_i(start_i),
      .player_hit_i(player_hit_i), .lives_i(lives_i), .enemy_killed_i(enemy_killed_i),
      .invaded_i(invaded_i), .run_o(run_o), .frame_o(frame_o), .level_reset_o(level_reset_o),
      .add_life_o(add_life_o), .level_o(level_o), .enemies_left_o(enemies_left_o),
      .score_o(score_o), .state_o(state_o), .hiscore_o(hiscore_o));

   function automatic void model_reset();
      m_state = 0; m_level = 1; m_left = E; m_score = 0; m_hi = 0; m_fcnt = 0;
      m_addlife = 0; m_lrst = 0; m_startq = 1;
   endfunction

   function automatic void model_step(bit f, bit s, bit hit, int lv, bit kill, bit inv);
      bit rise;
      rise = s && !m_startq;
      m_startq = s;
      m_lrst = 0;
      case (m_state)
         0, 5: if (rise) begin
            m_score = 0; m_level = 1; m_lrst = 1; m_state = 1; m_left = E; m_fcnt = 0;
         end
         1: if (f) begin
            m_addlife = 0;
            m_fcnt++;
            if (m_fcnt == D) m_state = 2;
         end
         2: begin
            if (kill) begin
               if (m_left > 0) m_left--;
               m_score = (m_score + K > 9999) ? 9999 : m_score + K;
            end
            if (inv || (hit && lv == 0)) begin
               m_state = 5;
               if (HI && m_score > m_hi) m_hi = m_score;
            end else if (hit) m_state = 3;
            else if (m_left == 0) m_state = 4;
         end
         3: if (rise) m_state = (m_left == 0) ? 4 : 2;
         4: begin
            m_level = (m_level == L) ? 1 : m_level + 1;
            if (m_level % 2 == 0) m_addlife = 1;
            m_lrst = 1; m_state = 1; m_left = E; m_fcnt = 0;
         end
         default: m_state = 0;
      endcase
   endfunction

   // drive one cycle of inputs, advance the model, land 1 time unit after the edge
   task automatic step(input bit f, input bit s, input bit hit, input int lv,
                       input bit kill, input bit inv);
      frame_i = f; start_i = s; player_hit_i = hit; lives_i = 2'(lv);
      enemy_killed_i = kill; invaded_i = inv;
      model_step(f, s, hit, lv, kill, inv);
      @(posedge clk_i); #1;
   endtask

   task automatic test_reset();
      reset_n_i = 0; start_i = 1; frame_i = 1; player_hit_i = 0; lives_i = 3;
      enemy_killed_i = 0; invaded_i = 0;
      model_reset();
      repeat (3) @(posedge clk_i);
      #1;
      n_checks += 6;
      if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state_o); end
      if (run_o !== 1'b0 || frame_o !== 1'b0) begin n_fail++; $display("FAIL reset_run got=%b/%b exp=0/0", run_o, frame_o); end
      if (level_o !== 4'd1) begin n_fail++; $display("FAIL reset_level got=%0d exp=1", level_o); end
      if (enemies_left_o !== 6'(E)) begin n_fail++; $display("FAIL reset_left got=%0d exp=%0d", enemies_left_o, E); end
      if (score_o !== 14'd0 || hiscore_o !== 14'd0) begin n_fail++; $display("FAIL reset_score got=%0d/%0d exp=0/0", score_o, hiscore_o); end
      if (level_reset_o !== 1'b0 || add_life_o !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got=%b/%b exp=0/0", level_reset_o, add_life_o); end
      reset_n_i = 1;
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 0, 3, 0, 0);
         n_checks++;
         if (state_o !== 3'd0) begin n_fail++; $display("FAIL held_start_idle got=%0d exp=0", state_o); end
      end
   endtask

   task automatic test_start();
      int pulses = 0;
      step(0, 0, 0, 3, 0, 0);
      step(0, 1, 0, 3, 0, 0);
      if (level_reset_o) pulses++;
      n_checks++;
      if (state_o !== 3'(m_state) || m_state != 1) begin n_fail++; $display("FAIL start_state got=%0d exp=1", state_o); end
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 3, 0, 0);
         if (level_reset_o) pulses++;
      end
      n_checks++;
      if (pulses != 1) begin n_fail++; $display("FAIL start_pulse_count got=%0d exp=1", pulses); end
      step(0, 0, 0, 3, 0, 0);
   endtask

   task automatic test_level_clear();
      step(1, 0, 0, 3, 0, 0);
      n_checks++;
      if (state_o !== 3'd1 || run_o !== 1'b0) begin n_fail++; $display("FAIL lvlstart_first_frame got=%0d/%b exp=1/0", state_o, run_o); end
      step(1, 0, 0, 3, 0, 0);
      n_checks++;
      if (state_o !== 3'd2 || run_o !== 1'b1) begin n_fail++; $display("FAIL enter_play got=%0d/%b exp=2/1", state_o, run_o); end
      for (int i = 0; i < 3; i++) step(0, 0, 0, 3, 1, 0);
      n_checks++;
      if (score_o !== 14'd30 || enemies_left_o !== 6'd0 || state_o !== 3'd4) begin
         n_fail++; $display("FAIL three_kills got=%0d/%0d/%0d exp=30/0/4", score_o, enemies_left_o, state_o);
      end
      step(0, 0, 0, 3, 0, 0);
      n_checks++;
      if (level_o !== 4'd2 || add_life_o !== 1'b1 || level_reset_o !== 1'b1 || state_o !== 3'd1) begin
         n_fail++; $display("FAIL clear_to_lvl2 got=%0d/%b/%b/%0d exp=2/1/1/1", level_o, add_life_o, level_reset_o, state_o);
      end
      step(0, 0, 0, 3, 0, 0);
      n_checks++;
      if (add_life_o !== 1'b1) begin n_fail++; $display("FAIL add_life_held got=%b exp=1", add_life_o); end
      step(1, 0, 0, 3, 0, 0);
      n_checks++;
      if (add_life_o !== 1'b0) begin n_fail++; $display("FAIL add_life_consumed got=%b exp=0", add_life_o); end
      step(1, 0, 0, 3, 0, 0);
      n_checks++;
      if (state_o !== 3'd2) begin n_fail++; $display("FAIL lvl2_play got=%0d exp=2", state_o); end
   endtask

   task automatic test_pause();
      step(0, 0, 1, 2, 0, 0);
      n_checks++;
      if (state_o !== 3'd3 || run_o !== 1'b0) begin n_fail++; $display("FAIL hit_pause got=%0d/%b exp=3/0", state_o, run_o); end
      step(1, 0, 0, 2, 0, 0);
      n_checks++;
      if (frame_o !== 1'b0) begin n_fail++; $display("FAIL paused_frame got=%b exp=0", frame_o); end
      step(0, 1, 0, 2, 0, 0);
      n_checks++;
      if (state_o !== 3'd2 || enemies_left_o !== 6'(E)) begin
         n_fail++; $display("FAIL resume got=%0d/%0d exp=2/%0d", state_o, enemies_left_o, E);
      end
      step(0, 0, 0, 2, 0, 0);
   endtask

   task automatic test_kill_hit_same();
      step(0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 1, 0);
      step(0, 0, 1, 1, 1, 0);
      n_checks++;
      if (state_o !== 3'd3 || score_o !== 14'(m_score) || m_score != 60 || enemies_left_o !== 6'd0) begin
         n_fail++; $display("FAIL kill_and_hit got=%0d/%0d/%0d exp=3/60/0", state_o, score_o, enemies_left_o);
      end
      step(0, 1, 0, 1, 0, 0);
      n_checks++;
      if (state_o !== 3'd4) begin n_fail++; $display("FAIL pause_to_clear got=%0d exp=4", state_o); end
      step(0, 0, 0, 1, 0, 0);
      n_checks++;
      if (level_o !== 4'd3 || add_life_o !== 1'b0) begin n_fail++; $display("FAIL lvl3_odd got=%0d/%b exp=3/0", level_o, add_life_o); end
      step(1, 0, 0, 1, 0, 0);
      step(1, 0, 0, 1, 0, 0);
   endtask

   task automatic test_gameover_hiscore();
      int first_hi;
      step(0, 0, 0, 3, 0, 1);
      first_hi = HI ? 60 : 0;
      n_checks++;
      if (state_o !== 3'd5 || run_o !== 1'b0) begin n_fail++; $display("FAIL invaded got=%0d/%b exp=5/0", state_o, run_o); end
      step(0, 0, 0, 3, 0, 0);
      n_checks++;
      if (hiscore_o !== 14'(first_hi) || score_o !== 14'd60) begin
         n_fail++; $display("FAIL hiscore_first got=%0d/%0d exp=%0d/60", hiscore_o, score_o, first_hi);
      end
      step(0, 1, 0, 3, 0, 0);
      n_checks++;
      if (score_o !== 14'd0 || state_o !== 3'd1 || level_o !== 4'd1) begin
         n_fail++; $display("FAIL new_game got=%0d/%0d/%0d exp=0/1/1", score_o, state_o, level_o);
      end
      step(1, 0, 0, 3, 0, 0);
      step(1, 0, 0, 3, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (state_o !== 3'd5 || hiscore_o !== 14'(first_hi) || score_o !== 14'd10) begin
         n_fail++; $display("FAIL hiscore_kept got=%0d/%0d/%0d exp=5/%0d/10", state_o, hiscore_o, score_o, first_hi);
      end
   endtask

   task automatic test_saturate_wrap();
      bit seen_9990 = 0, seen_wrap = 0;
      int prev_lvl;
      step(0, 1, 0, 3, 0, 0);
      for (int i = 0; i < 6000 && m_score != 9999; i++) begin
         prev_lvl = m_level;
         step(m_state == 1, 0, 0, 3, m_state == 2, 0);
         if (m_score == 9990) seen_9990 = 1;
         if (prev_lvl == L && m_level == 1) seen_wrap = 1;
         n_checks++;
         if (score_o !== 14'(m_score) || level_o !== 4'(m_level) || state_o !== 3'(m_state)) begin
            n_fail++; $display("FAIL sat_run got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                                score_o, level_o, state_o, m_score, m_level, m_state);
         end
      end
      n_checks++;
      if (score_o !== 14'd9999 || !seen_9990) begin n_fail++; $display("FAIL score_clamp got=%0d exp=9999", score_o); end
      n_checks++;
      if (!seen_wrap) begin n_fail++; $display("FAIL level_wrap got=none exp=%0d->1", L); end
      for (int i = 0; i < 20 && m_state != 5; i++) begin
         if (m_state == 2) step(0, 0, 0, 3, 1, 1);
         else step(m_state == 1, 0, 0, 3, 0, 0);
      end
      n_checks++;
      if (state_o !== 3'd5 || score_o !== 14'd9999 || hiscore_o !== (HI ? 14'd9999 : 14'd0)) begin
         n_fail++; $display("FAIL sat_gameover got=%0d/%0d/%0d exp=5/9999/%0d", state_o, score_o, hiscore_o, HI ? 9999 : 0);
      end
   endtask

   task automatic test_random();
      bit f, s, hit, kill, inv;
      int lv;
      for (int i = 0; i < 800; i++) begin
         f = ($urandom % 3) == 0; s = ($urandom % 6) == 0; hit = ($urandom % 12) == 0;
         kill = ($urandom % 3) == 0; inv = ($urandom % 60) == 0; lv = $urandom % 4;
         step(f, s, hit, lv, kill, inv);
         n_checks++;
         if (state_o !== 3'(m_state) || run_o !== (m_state == 2) || frame_o !== (f && m_state == 2)) begin
            n_fail++; $display("FAIL rnd_state cyc=%0d got=%0d/%b/%b exp=%0d", i, state_o, run_o, frame_o, m_state);
         end
         n_checks++;
         if (score_o !== 14'(m_score) || enemies_left_o !== 6'(m_left) || level_o !== 4'(m_level) || hiscore_o !== 14'(m_hi)) begin
            n_fail++; $display("FAIL rnd_counts cyc=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", i,
                               score_o, enemies_left_o, level_o, hiscore_o, m_score, m_left, m_level, m_hi);
         end
         n_checks++;
         if (level_reset_o !== m_lrst || add_life_o !== m_addlife) begin
            n_fail++; $display("FAIL rnd_pulses cyc=%0d got=%b/%b exp=%b/%b", i, level_reset_o, add_life_o, m_lrst, m_addlife);
         end
      end
   endtask

   task automatic test_reset_mid_play();
      for (int i = 0; i < 60 && m_state != 2; i++) step(m_state == 1, i % 2, 0, 3, 0, 0);
      step(0, 0, 0, 3, 1, 0);
      n_checks++;
      if (state_o !== 3'd2) begin n_fail++; $display("FAIL reach_play got=%0d exp=2", state_o); end
      frame_i = 1;
      #3 reset_n_i = 0;
      #1;
      n_checks++;
      if (state_o !== 3'd0 || run_o !== 1'b0 || frame_o !== 1'b0 || level_o !== 4'd1 ||
          enemies_left_o !== 6'(E) || score_o !== 14'd0 || hiscore_o !== 14'd0 ||
          level_reset_o !== 1'b0 || add_life_o !== 1'b0) begin
         n_fail++; $display("FAIL async_reset got=%0d/%b/%b/%0d/%0d/%0d/%0d exp=0/0/0/1/%0d/0/0",
                            state_o, run_o, frame_o, level_o, enemies_left_o, score_o, hiscore_o, E);
      end
      @(posedge clk_i); #1;
      reset_n_i = 1;
      model_reset();
      step(0, 0, 0, 3, 0, 0);
      n_checks++;
      if (state_o !== 3'd0) begin n_fail++; $display("FAIL post_reset_idle got=%0d exp=0", state_o); end
   endtask

   initial begin
      test_reset();
      test_start();
      test_level_clear();
      test_pause();
      test_kill_hit_same();
      test_gameover_hiscore();
      test_saturate_wrap();
      test_random();
      test_reset_mid_play();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
